// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a single-port RAM,
// one access per three cycles with fully registered outputs.
module ram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [1:0]          Req,
    input  logic [1:0]          Req_RW,
    input  logic [2*ADDR_W-1:0] Req_Addr,
    input  logic [2*DATA_W-1:0] Req_WData,
    output logic [1:0]          Ack,
    output logic [DATA_W-1:0]   RData,
    output logic                Busy,
    output logic                Mem_Enable,
    output logic                Mem_RW,
    output logic [ADDR_W-1:0]   Mem_Address,
    output logic [DATA_W-1:0]   Mem_In,
    input  logic [DATA_W-1:0]   Mem_Out
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state, state_nx;
    logic                grant, grant_nx;
    logic                last, last_nx;
    logic                pick;
    logic [1:0]          ack_nx;
    logic [DATA_W-1:0]   rdata_nx;
    logic                busy_nx;
    logic                en_nx;
    logic                rw_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   in_nx;

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    assign pick = (Req == 2'b11) ? ~last : Req[1];

    // State register, grant index and round-robin pointer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            last  <= last_nx;
        end
    end

    // Next state plus next value of every output; outputs default to their idle values.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last;
        ack_nx   = 2'b00;
        rdata_nx = RData;
        busy_nx  = 1'b0;
        en_nx    = 1'b0;
        rw_nx    = 1'b1;
        addr_nx  = '0;
        in_nx    = '0;
        case (state)
            IDLE: begin
                if (|Req) begin
                    state_nx = ACCESS;
                    grant_nx = pick;
                    busy_nx  = 1'b1;
                    en_nx    = 1'b1;
                    rw_nx    = Req_RW[pick];
                    addr_nx  = pick ? Req_Addr[2*ADDR_W-1:ADDR_W] : Req_Addr[ADDR_W-1:0];
                    in_nx    = pick ? Req_WData[2*DATA_W-1:DATA_W] : Req_WData[DATA_W-1:0];
                end
            end
            ACCESS: begin
                state_nx = DONE;
                busy_nx  = 1'b1;
                ack_nx   = grant ? 2'b10 : 2'b01;
                rdata_nx = Mem_RW ? Mem_Out : RData;
            end
            DONE: begin
                state_nx = IDLE;
                last_nx  = grant;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output flops; reset aborts any transaction in flight without Ack or RData update.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Ack         <= 2'b00;
            RData       <= '0;
            Busy        <= 1'b0;
            Mem_Enable  <= 1'b0;
            Mem_RW      <= 1'b1;
            Mem_Address <= '0;
            Mem_In      <= '0;
        end else begin
            Ack         <= ack_nx;
            RData       <= rdata_nx;
            Busy        <= busy_nx;
            Mem_Enable  <= en_nx;
            Mem_RW      <= rw_nx;
            Mem_Address <= addr_nx;
            Mem_In      <= in_nx;
        end
    end

    a_ack_onehot: assert property (@(posedge Clk) disable iff (!Rst_n) $onehot0(Ack));
    a_en_access:  assert property (@(posedge Clk) disable iff (!Rst_n) Mem_Enable |-> state == ACCESS);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural RAM and reference memory.
module tb_ram_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [1:0]  Req = 2'b00;
    logic [1:0]  Req_RW = 2'b11;
    logic [31:0] Req_Addr = '0;
    logic [63:0] Req_WData = '0;
    logic [1:0]  Ack;
    logic [31:0] RData;
    logic        Busy;
    logic        Mem_Enable;
    logic        Mem_RW;
    logic [15:0] Mem_Address;
    logic [31:0] Mem_In;
    logic [31:0] Mem_Out;

    typedef struct {
        logic [1:0]  ack;
        logic        rw;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          en_cyc;
        int          ack_cyc;
        int          gap;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ram [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] last_rd = '0;
    logic        preload = 1'b1;
    int          cyc = 0;
    int          last_ack = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    ram_arbiter #(.DATA_W(32), .ADDR_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Req_RW(Req_RW), .Req_Addr(Req_Addr),
        .Req_WData(Req_WData), .Ack(Ack), .RData(RData), .Busy(Busy),
        .Mem_Enable(Mem_Enable), .Mem_RW(Mem_RW), .Mem_Address(Mem_Address),
        .Mem_In(Mem_In), .Mem_Out(Mem_Out)
    );

    always #5 Clk = ~Clk;

    // Behavioural RAM: combinational read, synchronous write.
    assign Mem_Out = ram[Mem_Address[7:0]];
    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= (i == 3) ? 32'hDEADBEEF : 32'h1000_0000 + i;
        end else if (Mem_Enable && !Mem_RW) begin
            ram[Mem_Address[7:0]] <= Mem_In;
        end
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected results come from the reference memory, updated in issue order.
    task automatic push(input logic [1:0] ack, input logic rw, input logic [15:0] addr,
                        input logic [31:0] wd, input int en_cyc, input int ack_cyc, input int gap);
        ent_t e;
        if (rw) last_rd = ref_mem[addr[7:0]];
        else ref_mem[addr[7:0]] = wd;
        e.ack = ack; e.rw = rw; e.addr = addr; e.wdata = wd; e.rdata = last_rd;
        e.en_cyc = en_cyc; e.ack_cyc = ack_cyc; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(posedge Clk);
            #1;
        end
        if (q.size() != 0) begin
            check("timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic xfer(input logic [1:0] req, input logic [1:0] rw, input logic [15:0] a0,
                        input logic [15:0] a1, input logic [31:0] w0, input logic [31:0] w1,
                        input logic g);
        Req = req; Req_RW = rw; Req_Addr = {a1, a0}; Req_WData = {w1, w0};
        push(g ? 2'b10 : 2'b01, rw[g], g ? a1 : a0, g ? w1 : w0, cyc + 1, cyc + 2, 0);
        drain();
        Req = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 64'(Ack), 64'd0);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_en"}, 64'(Mem_Enable), 64'd0);
        check({tag, "_rw"}, 64'(Mem_RW), 64'd1);
        check({tag, "_addr"}, 64'(Mem_Address), 64'd0);
        check({tag, "_in"}, 64'(Mem_In), 64'd0);
        check({tag, "_rdata"}, 64'(RData), 64'd0);
    endtask

    // Monitor: memory-side beats and Ack pulses are matched against the scoreboard head.
    always @(negedge Clk) begin
        ent_t e;
        if (Rst_n) begin
            if (Mem_Enable) begin
                check("busy_en", 64'(Busy), 64'd1);
                if (q.size() == 0) check("en_spurious", 64'd1, 64'd0);
                else begin
                    e = q[0];
                    check("mem_rw", 64'(Mem_RW), 64'(e.rw));
                    check("mem_addr", 64'(Mem_Address), 64'(e.addr));
                    if (!e.rw) check("mem_in", 64'(Mem_In), 64'(e.wdata));
                    if (e.en_cyc >= 0) check("en_lat", 64'(cyc), 64'(e.en_cyc));
                end
            end
            if (Ack != 2'b00) begin
                check("en_in_done", 64'(Mem_Enable), 64'd0);
                if (q.size() == 0) check("ack_spurious", 64'(Ack), 64'd0);
                else begin
                    e = q.pop_front();
                    check("ack", 64'(Ack), 64'(e.ack));
                    check("rdata", 64'(RData), 64'(e.rdata));
                    if (e.ack_cyc >= 0) check("ack_lat", 64'(cyc), 64'(e.ack_cyc));
                    if (e.gap > 0) check("ack_gap", 64'(cyc - last_ack), 64'(e.gap));
                end
                last_ack = cyc;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = (i == 3) ? 32'hDEADBEEF : 32'h1000_0000 + i;
        repeat (2) @(posedge Clk);
        preload = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("idle");

        // Single read of the preloaded word.
        xfer(2'b01, 2'b11, 16'd3, 16'd0, 32'h0, 32'h0, 1'b0);
        // Requester 1 writes then reads back.
        xfer(2'b10, 2'b00, 16'd0, 16'd7, 32'h0, 32'h12345678, 1'b1);
        xfer(2'b10, 2'b10, 16'd0, 16'd7, 32'h0, 32'h0, 1'b1);
        // Requester 0 write to a different address, then read by requester 1.
        xfer(2'b01, 2'b10, 16'd9, 16'd0, 32'hCAFE0009, 32'h0, 1'b0);
        xfer(2'b10, 2'b11, 16'd0, 16'd9, 32'h0, 32'h0, 1'b1);

        // Requests change during ACCESS: the latched transaction must complete unchanged.
        Req = 2'b01; Req_RW = 2'b01; Req_Addr = {16'd0, 16'd5};
        push(2'b01, 1'b1, 16'd5, 32'h0, cyc + 1, cyc + 2, 0);
        @(posedge Clk);
        #1;
        Req = 2'b00; Req_RW = 2'b00; Req_Addr = {16'd0, 16'd9};
        drain();

        // Reset during ACCESS aborts without Ack; afterwards requester 0 wins the tie.
        Req = 2'b01; Req_RW = 2'b11; Req_Addr = {16'd7, 16'd3};
        @(posedge Clk);
        #1;
        check("abort_en_before", 64'(Mem_Enable), 64'd1);
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        Req = 2'b11;
        last_rd = '0;
        push(2'b01, 1'b1, 16'd3, 32'h0, -1, -1, 0);
        repeat (2) @(posedge Clk);
        #1;
        check("abort_hold_ack", 64'(Ack), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        drain();
        Req = 2'b00;
        repeat (3) @(posedge Clk);

        // Round-robin with both requests held from reset.
        Rst_n = 1'b0;
        #1;
        last_rd = '0;
        Req = 2'b11; Req_RW = 2'b11; Req_Addr = {16'd20, 16'd10};
        push(2'b01, 1'b1, 16'd10, 32'h0, -1, -1, 0);
        push(2'b10, 1'b1, 16'd20, 32'h0, -1, -1, 3);
        push(2'b01, 1'b1, 16'd10, 32'h0, -1, -1, 3);
        push(2'b10, 1'b1, 16'd20, 32'h0, -1, -1, 3);
        @(negedge Clk);
        Rst_n = 1'b1;
        drain();
        Req = 2'b00;
        repeat (4) @(posedge Clk);
        #1;
        check("final_busy", 64'(Busy), 64'd0);
        check("final_q", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the RAM data width.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning the RAM address width.
REQ-003 The block SHALL have port Clk  input  1  as its single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port Rst_n  input  1  as its reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port Req  input  2  carrying the per-requester access request, with bit i for requester i.
REQ-006 The block SHALL have port Req_RW  input  2  carrying the per-requester direction, where 1 = read and 0 = write.
REQ-007 The block SHALL have port Req_Addr  input  2*ADDR_W  carrying the requester addresses, packed as {req1, req0}.
REQ-008 The block SHALL have port Req_WData  input  2*DATA_W  carrying the requester write data, packed as {req1, req0}.
REQ-009 The block SHALL have port Ack  output  2  carrying the one-cycle completion pulse, with bit i for requester i.
REQ-010 The block SHALL have port RData  output  DATA_W  carrying read data, valid while Ack is high.
REQ-011 The block SHALL have port Busy  output  1  that is high while the state is not IDLE.
REQ-012 The block SHALL have port Mem_Enable  output  1  driving the RAM Enable input.
REQ-013 The block SHALL have port Mem_RW  output  1  driving the RAM RW input (1 = read).
REQ-014 The block SHALL have ports Mem_Address  output  ADDR_W  and Mem_In  output  DATA_W  driving the RAM Address and In inputs.
REQ-015 The block SHALL have port Mem_Out  input  DATA_W  carrying the RAM combinational read data.

Function
REQ-016 All outputs SHALL be registered, driven directly from flops.
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-018 In IDLE with Req==0, the FSM SHALL remain in IDLE and all outputs SHALL hold their reset values, except RData, which holds its last value.
REQ-019 In IDLE with any Req bit set, the block SHALL select a grant index g, latch Req_RW[g], Req_Addr slice g and Req_WData slice g, and go to ACCESS.
REQ-020 Selection SHALL follow these rules:
  - only one Req bit set: that requester wins;
  - both bits set: the requester other than pointer Last wins (round-robin).
REQ-021 In ACCESS, Mem_Enable SHALL be 1 for exactly one cycle, with Mem_RW, Mem_Address and Mem_In equal to the latched values.
REQ-022 At the edge that ends ACCESS, a read SHALL capture Mem_Out into RData, and a write SHALL leave RData unchanged; the FSM then goes to DONE.
REQ-023 In DONE, the block SHALL hold Ack[g]=1 for one cycle, deassert Mem_Enable, set Last<=g, and return to IDLE.
REQ-024 Latency SHALL be fixed: a Req sampled in IDLE at edge k produces Mem_Enable high during cycle k+1 and Ack high during cycle k+2.
REQ-025 Maximum throughput SHALL be one access per 3 cycles.
REQ-026 Request inputs SHALL be sampled only in IDLE; changes to Req, Req_RW, Req_Addr or Req_WData during ACCESS or DONE SHALL not affect the current transaction.
REQ-027 If Req[g] drops after the grant, the transaction SHALL still complete and Ack[g] SHALL still pulse.
REQ-028 A requester SHALL deassert Req in the cycle Ack is high; a Req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-029 Ack SHALL never be one-hot violated; at most one bit is set at any time.
REQ-030 Mem_Enable SHALL never be high in IDLE or DONE.

Reset
REQ-031 On Rst_n low, the block SHALL immediately, without waiting for Clk, force the following values:
  - state=IDLE;
  - Mem_Enable=0, Mem_RW=1, Mem_Address=0, Mem_In=0;
  - Ack=0, RData=0, Busy=0;
  - Last=1, so requester 0 wins the first tie.
REQ-032 A reset asserted during ACCESS or DONE SHALL abort the transaction with no Ack and no RData update.
REQ-033 After Rst_n rises, the first arbitration SHALL occur at the first Clk edge that samples a Req bit in IDLE.

Verification
REQ-034 The bench SHALL cover a single read: RAM preloaded with Mem[3]=0xDEADBEEF, Req=01, Req_RW=11, addr0=3 -> Mem_Enable=1, Mem_RW=1, Mem_Address=3 one cycle later; Ack=01 and RData=0xDEADBEEF the cycle after.
REQ-035 The bench SHALL cover a write then read-back: requester 1 writes 0x12345678 to address 7 (Ack=10, RData unchanged), then reads address 7 -> RData=0x12345678.
REQ-036 The bench SHALL cover round-robin: Req=11 held from reset -> Ack sequence 01, 10, 01, 10 with 3-cycle spacing, and Mem_Address alternating addr0/addr1.
REQ-037 The bench SHALL cover request changes mid-transaction: Req0 drops and addr0 changes during ACCESS -> original address used and Ack=01 still pulses.
REQ-038 The bench SHALL cover reset mid-operation: Rst_n low during ACCESS -> Mem_Enable=0 at once, no Ack, Busy=0; after release with Req=11 -> requester 0 granted first.
